spi_io_ctrl: RTL

CPU-side sequencer that sits directly upstream of the SPI interface block.
- Converts a single-cycle CPU I/O load/store request into the read/send/driver-select handshake the SPI interface expects.
- Stalls the CPU while the serial transfer runs.
- Returns received data, plus the received address field when the transfer is in external-driver mode.
- Watchdog timeout reports a hung transfer instead of stalling the CPU forever.

---
 rtl/spi_io_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/spi_io_ctrl.sv
// CPU-side sequencer for the SPI interface: turns a one-cycle I/O request
// into the read/send/driver-select handshake and stalls the CPU meanwhile.
module spi_io_ctrl #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int TIMEOUT   = 32,
    parameter int TIMEOUT_W = $clog2(TIMEOUT) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_in,
    input  logic              cpu_we_in,
    input  logic              cpu_ext_in,
    input  logic [DATA_W-1:0] cpu_wdata_in,
    output logic              cpu_busy_out,
    output logic              cpu_done_out,
    output logic              cpu_err_out,
    output logic [DATA_W-1:0] cpu_rdata_out,
    output logic [ADDR_W-1:0] ext_addr_out,
    output logic              spi_read_out,
    output logic              spi_send_out,
    output logic              spi_driver_io_out,
    output logic [DATA_W-1:0] spi_wdata_out,
    input  logic              spi_ready_in,
    input  logic [DATA_W-1:0] spi_rdata_in,
    input  logic [ADDR_W-1:0] spi_addr_in
);

    typedef enum logic [2:0] {
        IDLE, LAUNCH, WAIT, DONE, ERR
    } state_t;

    localparam logic [TIMEOUT_W-1:0] WDOG_LAST = TIMEOUT_W'(TIMEOUT - 1);

    state_t              state_q;
    logic                we_q;
    logic                ext_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [TIMEOUT_W-1:0] wdog_q;
    logic [TIMEOUT_W-1:0] wdog_d;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic                send_q;
    logic                read_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [ADDR_W-1:0]   addr_q;

    // Saturating so a stuck count can never wrap back below the limit
    assign wdog_d = (wdog_q == '1) ? wdog_q : wdog_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            ext_q   <= 1'b0;
            wdata_q <= '0;
            wdog_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            send_q  <= 1'b0;
            read_q  <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cpu_req_in) begin
                        we_q    <= cpu_we_in;
                        ext_q   <= cpu_ext_in;
                        wdata_q <= cpu_wdata_in;
                        busy_q  <= 1'b1;
                        send_q  <= cpu_we_in;
                        read_q  <= ~cpu_we_in;
                        state_q <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    wdog_q  <= '0;
                    send_q  <= 1'b0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    wdog_q <= wdog_d;
                    if (spi_ready_in) begin
                        if (!we_q) rdata_q <= spi_rdata_in;
                        if (ext_q) addr_q <= spi_addr_in;
                        busy_q  <= 1'b0;
                        read_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (wdog_q == WDOG_LAST) begin
                        busy_q  <= 1'b0;
                        read_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= ERR;
                    end
                end
                DONE, ERR: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // busy_q covers LAUNCH/WAIT; the request cycle itself stalls combinationally
    assign cpu_busy_out      = busy_q | ((state_q == IDLE) & cpu_req_in);
    assign cpu_done_out      = done_q;
    assign cpu_err_out       = err_q;
    assign cpu_rdata_out     = rdata_q;
    assign ext_addr_out      = addr_q;
    assign spi_send_out      = send_q;
    assign spi_read_out      = read_q;
    assign spi_driver_io_out = busy_q & ext_q;
    assign spi_wdata_out     = busy_q ? wdata_q : '0;

endmodule
